// File: rtl/copro_issue_ctrl.sv
// Issue controller for multi-cycle coprocessor opcodes: latches operands, starts one unit,
// stalls decode until done or timeout, then produces a single-cycle register writeback.
module copro_issue_ctrl #(
    parameter int         XLEN      = 32,
    parameter int         NUM_UNITS = 2,
    parameter logic [6:0] OP_BASE   = 7'b0000000,
    parameter int         TIMEOUT   = 255
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      instr_valid,
    input  logic [6:0]                op,
    input  logic [4:0]                rd,
    input  logic [XLEN-1:0]           srca,
    input  logic [XLEN-1:0]           srcb,
    input  logic                      flush,
    output logic                      is_copro,
    output logic                      stall,
    output logic [NUM_UNITS-1:0]      cp_start,
    output logic [XLEN-1:0]           cp_a,
    output logic [XLEN-1:0]           cp_b,
    input  logic [NUM_UNITS-1:0]      cp_done,
    input  logic [NUM_UNITS*XLEN-1:0] cp_result,
    output logic                      wb_en,
    output logic [4:0]                wb_rd,
    output logic [XLEN-1:0]           wb_data,
    output logic                      cp_timeout
);

    localparam int UW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, START, WAIT, WB} state_t;

    state_t          state;
    logic [UW-1:0]   unit;
    logic [TW-1:0]   timer;
    logic [7:0]      op_off;
    logic            issue;

    // Ops below OP_BASE wrap to a large offset, so one unsigned compare covers both bounds.
    assign op_off   = {1'b0, op} - {1'b0, OP_BASE};
    assign is_copro = (op_off < 8'(NUM_UNITS));
    assign issue    = instr_valid & is_copro & ~flush;

    assign stall = reset_n & (((state == IDLE) & issue) | (state == START) | (state == WAIT));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            unit       <= '0;
            timer      <= '0;
            cp_start   <= '0;
            cp_a       <= '0;
            cp_b       <= '0;
            wb_en      <= 1'b0;
            wb_rd      <= '0;
            wb_data    <= '0;
            cp_timeout <= 1'b0;
        end else begin
            cp_start <= '0;
            wb_en    <= 1'b0;
            case (state)
                IDLE: begin
                    if (issue) begin
                        unit     <= op_off[UW-1:0];
                        wb_rd    <= rd;
                        cp_a     <= srca;
                        cp_b     <= srcb;
                        cp_start <= NUM_UNITS'(1) << op_off[UW-1:0];
                        state    <= START;
                    end
                end
                START: begin
                    timer <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    timer <= timer + TW'(1);
                    // done wins over a timeout landing in the same cycle
                    if (cp_done[unit]) begin
                        wb_data <= cp_result[int'(unit)*XLEN +: XLEN];
                        wb_en   <= (wb_rd != 5'd0);
                        state   <= WB;
                    end else if (timer == TW'(TIMEOUT - 1)) begin
                        cp_timeout <= 1'b1;
                        wb_data    <= '0;
                        wb_en      <= (wb_rd != 5'd0);
                        state      <= WB;
                    end
                end
                WB:      state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_copro_issue_ctrl.sv
// Directed bench for copro_issue_ctrl: issue/stall/writeback timing, unit selection,
// rd=0 suppression, flush, timeout and asynchronous reset mid-operation.
module tb_copro_issue_ctrl;

    localparam int XLEN = 32;
    localparam int NU   = 2;
    localparam int TO   = 8;

    logic                 clk = 1'b0;
    logic                 reset_n;
    logic                 instr_valid;
    logic [6:0]           op;
    logic [4:0]           rd;
    logic [XLEN-1:0]      srca, srcb;
    logic                 flush;
    logic                 is_copro, stall;
    logic [NU-1:0]        cp_start;
    logic [XLEN-1:0]      cp_a, cp_b;
    logic [NU-1:0]        cp_done;
    logic [NU*XLEN-1:0]   cp_result;
    logic                 wb_en;
    logic [4:0]           wb_rd;
    logic [XLEN-1:0]      wb_data;
    logic                 cp_timeout;

    int n_cmp = 0;
    int n_err = 0;

    copro_issue_ctrl #(.XLEN(XLEN), .NUM_UNITS(NU), .OP_BASE(7'b0000000), .TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n), .instr_valid(instr_valid), .op(op), .rd(rd),
        .srca(srca), .srcb(srcb), .flush(flush), .is_copro(is_copro), .stall(stall),
        .cp_start(cp_start), .cp_a(cp_a), .cp_b(cp_b), .cp_done(cp_done),
        .cp_result(cp_result), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .cp_timeout(cp_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // d = cycles after START at which the selected unit raises done; 0 = never (timeout)
    task automatic run_op(input logic [6:0] o, input logic [4:0] r, input logic [31:0] a,
                          input logic [31:0] b, input int d, input logic [31:0] res,
                          input bit other_pulse, input bit exp_tf);
        int u;
        int nwait;
        u = int'(o);
        instr_valid = 1'b1; op = o; rd = r; srca = a; srcb = b; flush = 1'b0; cp_done = '0;
        for (int k = 0; k < NU; k++) cp_result[k*XLEN +: XLEN] = (k == u) ? res : 32'hdeadbeef;
        #1;
        chk("issue_is_copro", is_copro, 1);
        chk("issue_stall", stall, 1);
        chk("issue_no_start", cp_start, 0);
        cyc();
        #1;
        chk("start_onehot", cp_start, 64'(1) << u);
        chk("start_stall", stall, 1);
        chk("start_cp_a", cp_a, a);
        chk("start_cp_b", cp_b, b);
        nwait = (d == 0) ? TO : d;
        for (int i = 1; i <= nwait; i++) begin
            cyc();
            cp_done = '0;
            if (i == d) cp_done[u] = 1'b1;
            if (other_pulse) cp_done[1-u] = 1'b1;
            #1;
            chk("wait_stall", stall, 1);
            chk("wait_no_start", cp_start, 0);
            chk("wait_no_wb", wb_en, 0);
        end
        cyc();
        cp_done = '0; instr_valid = 1'b0;
        #1;
        chk("wb_en", wb_en, (r != 5'd0));
        chk("wb_rd", wb_rd, r);
        chk("wb_data", wb_data, (d == 0) ? 32'd0 : res);
        chk("wb_stall", stall, 0);
        chk("wb_timeout_flag", cp_timeout, exp_tf);
        cyc();
        #1;
        chk("post_wb_en", wb_en, 0);
        chk("post_stall", stall, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; instr_valid = 1'b1; op = 7'd0; rd = 5'd1; srca = '1; srcb = '1;
        flush = 1'b0; cp_done = '0; cp_result = '0;
        repeat (2) @(posedge clk);
        #2;
        chk("rst_stall", stall, 0);
        chk("rst_start", cp_start, 0);
        chk("rst_wb_en", wb_en, 0);
        chk("rst_wb_rd", wb_rd, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_cp_a", cp_a, 0);
        chk("rst_timeout", cp_timeout, 0);
        instr_valid = 1'b0;
        #2 reset_n = 1'b1;
        cyc();

        // gcd 48,18 -> 6, done three cycles after start
        run_op(7'd0, 5'd5, 32'd48, 32'd18, 3, 32'd6, 1'b0, 1'b0);
        // lcm 4,6 -> 12 with unit0 done chattering
        run_op(7'd1, 5'd7, 32'd4, 32'd6, 2, 32'd12, 1'b1, 1'b0);
        // rd = 0: full sequence, no write
        run_op(7'd0, 5'd0, 32'd27, 32'd9, 2, 32'd9, 1'b0, 1'b0);

        // flushed copro op is not issued
        instr_valid = 1'b1; op = 7'd1; rd = 5'd3; flush = 1'b1;
        #1;
        chk("flush_stall", stall, 0);
        cyc();
        chk("flush_no_start", cp_start, 0);
        chk("flush_still_idle", stall, 0);
        flush = 1'b0; op = 7'b0110011;
        #1;
        chk("rtype_is_copro", is_copro, 0);
        chk("rtype_stall", stall, 0);
        cyc();
        chk("rtype_no_start", cp_start, 0);
        instr_valid = 1'b0;
        cyc();

        // no done: abort after TIMEOUT wait cycles
        run_op(7'd0, 5'd3, 32'd1, 32'd2, 0, 32'd0, 1'b0, 1'b1);
        // flag stays sticky through a good op
        run_op(7'd1, 5'd6, 32'd10, 32'd4, 2, 32'h55, 1'b0, 1'b1);

        // asynchronous reset in the middle of WAIT
        instr_valid = 1'b1; op = 7'd1; rd = 5'd9; srca = 32'd3; srcb = 32'd5;
        cyc(); cyc(); cyc();
        instr_valid = 1'b0;
        #2 reset_n = 1'b0;
        #1;
        chk("mid_rst_stall", stall, 0);
        chk("mid_rst_start", cp_start, 0);
        chk("mid_rst_wb_en", wb_en, 0);
        chk("mid_rst_timeout", cp_timeout, 0);
        cyc();
        #2 reset_n = 1'b1;
        cyc();
        // minimum latency op after release
        run_op(7'd0, 5'd4, 32'd10, 32'd15, 1, 32'd5, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
